// File: rtl/nand_flash_array_pkg.sv
// Shared definitions for the NAND flash array model: controller-facing
// command codes, the array FSM state type and default geometry.
package NandFlashDefs;

  // Command codes, identical to the controller's mem_* encodings
  localparam logic [2:0] MEM_ERASE        = 3'd0;
  localparam logic [2:0] MEM_PROGRAM_PAGE = 3'd1;
  localparam logic [2:0] MEM_PAGE_READ    = 3'd2;

  // Default geometry and the index widths / depth it implies
  localparam int DEF_PAGE_WORDS      = 8;
  localparam int DEF_PAGES_PER_BLOCK = 4;
  localparam int DEF_NUM_BLOCKS      = 4;
  localparam int DEF_WORD_BITS       = $clog2(DEF_PAGE_WORDS);
  localparam int DEF_PAGE_BITS       = $clog2(DEF_PAGES_PER_BLOCK);
  localparam int DEF_BLOCK_BITS      = $clog2(DEF_NUM_BLOCKS);
  localparam int DEF_NUM_PAGES       = DEF_PAGES_PER_BLOCK * DEF_NUM_BLOCKS;
  localparam int DEF_DEPTH           = DEF_NUM_PAGES * DEF_PAGE_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PROG_LOAD  = 3'd1,
    ST_PROG_BUSY  = 3'd2,
    ST_ERASE_BUSY = 3'd3,
    ST_READ_BUSY  = 3'd4,
    ST_READ_OUT   = 3'd5
  } array_state_t;

  // Index width for n entries, never below one bit
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nand_flash_array_busy_timer.sv
// R/B# busy timer: loaded with N-1 on start, counts down to zero, flags
// the final busy cycle. Shared by erase, program and read.
module nand_busy_timer #(
  parameter int Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] load_i,
  output logic             busy_o,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Next-state: start wins, otherwise count down and stop at zero
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = load_i;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  // Timer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign last_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/nand_flash_array.sv
// Cycle-based NAND flash array: erase/program/read with R/B# timing and
// flash bit semantics (erase -> ones, program only clears bits).
module nand_flash_array
  import NandFlashDefs::*;
#(
  parameter int DataWidth     = 16,
  parameter int AddressWidth  = 16,
  parameter int PageWords     = DEF_PAGE_WORDS,
  parameter int PagesPerBlock = DEF_PAGES_PER_BLOCK,
  parameter int NumBlocks     = DEF_NUM_BLOCKS,
  parameter int EraseCycles   = 16,
  parameter int ProgramCycles = 8,
  parameter int ReadCycles    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [2:0]              cmd_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wr_data_i,
  input  logic                    wr_valid_i,
  output logic [DataWidth-1:0]    rd_data_o,
  output logic                    rd_valid_o,
  output logic                    busy_n_o,
  output logic                    op_done_o,
  output logic                    op_err_o
);

  localparam int NumPages  = PagesPerBlock * NumBlocks;
  localparam int WordBits  = idx_bits(PageWords);
  localparam int PageBits  = idx_bits(PagesPerBlock);
  localparam int RowBits   = idx_bits(NumPages);
  localparam int BlkFieldW = AddressWidth - PageBits;
  localparam int MaxCyc01  = (EraseCycles > ProgramCycles) ? EraseCycles : ProgramCycles;
  localparam int MaxCycles = (MaxCyc01 > ReadCycles) ? MaxCyc01 : ReadCycles;
  localparam int TimerW    = idx_bits(MaxCycles);

  array_state_t                                 state_q, state_d;
  logic [WordBits-1:0]                          word_cnt_q, word_cnt_d;
  logic [RowBits-1:0]                           row_q, row_d;
  logic                                         op_done_q, op_done_d;
  logic                                         op_err_q, op_err_d;
  logic [PageWords-1:0][DataWidth-1:0]          page_buf_q, page_buf_d;
  // Array stored inverted: a zero bit means erased, so a zero-initialised
  // storage element powers up reading as all-ones.
  logic [NumPages-1:0][PageWords-1:0][DataWidth-1:0] mem_q, mem_d;

  logic                 accept, blk_ok, cmd_ok;
  logic [BlkFieldW-1:0] blk_field;
  logic                 tmr_start, tmr_busy, tmr_last;
  logic [TimerW-1:0]    tmr_load;
  logic                 erase_commit, prog_commit, read_copy, buf_load;
  logic                 last_word;

  assign accept    = cmd_valid_i && cmd_ready_o;
  assign blk_field = addr_i[AddressWidth-1:PageBits];
  assign blk_ok    = blk_field < BlkFieldW'(NumBlocks);
  assign cmd_ok    = (cmd_i == MEM_ERASE) || (cmd_i == MEM_PROGRAM_PAGE) ||
                     (cmd_i == MEM_PAGE_READ);
  assign last_word = word_cnt_q == WordBits'(PageWords - 1);

  nand_busy_timer #(.Width(TimerW)) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (tmr_start),
    .load_i  (tmr_load),
    .busy_o  (tmr_busy),
    .last_o  (tmr_last)
  );

  // Control FSM next-state and timer launch
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    row_d      = row_q;
    op_done_d  = 1'b0;
    op_err_d   = 1'b0;
    tmr_start  = 1'b0;
    tmr_load   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!cmd_ok || !blk_ok) begin
            op_err_d = 1'b1;
          end else begin
            // Power-of-two geometry: the low row bits are the linear page index
            row_d      = addr_i[RowBits-1:0];
            word_cnt_d = '0;
            if (cmd_i == MEM_ERASE) begin
              state_d   = ST_ERASE_BUSY;
              tmr_start = 1'b1;
              tmr_load  = TimerW'(EraseCycles - 1);
            end else if (cmd_i == MEM_PROGRAM_PAGE) begin
              state_d = ST_PROG_LOAD;
            end else begin
              state_d   = ST_READ_BUSY;
              tmr_start = 1'b1;
              tmr_load  = TimerW'(ReadCycles - 1);
            end
          end
        end
      end
      ST_PROG_LOAD: begin
        if (wr_valid_i) begin
          if (last_word) begin
            state_d   = ST_PROG_BUSY;
            tmr_start = 1'b1;
            tmr_load  = TimerW'(ProgramCycles - 1);
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      ST_PROG_BUSY, ST_ERASE_BUSY: begin
        if (tmr_last) begin
          state_d   = ST_IDLE;
          op_done_d = 1'b1;
        end
      end
      ST_READ_BUSY: begin
        if (tmr_last) begin
          state_d    = ST_READ_OUT;
          word_cnt_d = '0;
        end
      end
      ST_READ_OUT: begin
        if (last_word) begin
          state_d   = ST_IDLE;
          op_done_d = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      row_q      <= '0;
      op_done_q  <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      row_q      <= row_d;
      op_done_q  <= op_done_d;
      op_err_q   <= op_err_d;
    end
  end

  assign erase_commit = (state_q == ST_ERASE_BUSY) && tmr_last;
  assign prog_commit  = (state_q == ST_PROG_BUSY)  && tmr_last;
  assign read_copy    = (state_q == ST_READ_BUSY)  && tmr_last;
  assign buf_load     = (state_q == ST_PROG_LOAD)  && wr_valid_i;

  // Array and page buffer update; the array changes only on a commit cycle
  always_comb begin
    mem_d      = mem_q;
    page_buf_d = page_buf_q;
    if (buf_load)  page_buf_d[word_cnt_q] = wr_data_i;
    if (read_copy) page_buf_d = ~mem_q[row_q];
    if (prog_commit) mem_d[row_q] = mem_q[row_q] | ~page_buf_q;
    if (erase_commit) begin
      for (int r = 0; r < NumPages; r++) begin
        if ((r / PagesPerBlock) == (int'(row_q) / PagesPerBlock)) mem_d[r] = '0;
      end
    end
  end

  // Storage holds its contents through reset
  always_ff @(posedge clk_i) begin
    mem_q      <= mem_d;
    page_buf_q <= page_buf_d;
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_n_o    = ~tmr_busy;
  assign rd_valid_o  = (state_q == ST_READ_OUT);
  assign rd_data_o   = rd_valid_o ? page_buf_q[word_cnt_q] : '0;
  assign op_done_o   = op_done_q;
  assign op_err_o    = op_err_q;

endmodule

// File: tb/tb_nand_flash_array.sv
// Randomized scoreboard bench for nand_flash_array: drivers push expected
// read words and completion events, a monitor pops them as the DUT emits.
`timescale 1ns/1ps
module tb_nand_flash_array;
  import NandFlashDefs::*;

  localparam int DW = 16, AW = 16;
  localparam int PW = DEF_PAGE_WORDS, PPB = DEF_PAGES_PER_BLOCK, NB = DEF_NUM_BLOCKS;
  localparam int NPAGES = DEF_NUM_PAGES;
  localparam int EC = 16, PC = 8, RC = 4;
  localparam int EV_DONE = 1, EV_ERR = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [2:0]    cmd = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic          wr_valid = 1'b0, rd_valid, busy_n, op_done, op_err;

  always #5 clk = ~clk;

  nand_flash_array #(
    .DataWidth(DW), .AddressWidth(AW), .PageWords(PW), .PagesPerBlock(PPB),
    .NumBlocks(NB), .EraseCycles(EC), .ProgramCycles(PC), .ReadCycles(RC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_i(cmd), .addr_i(addr), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_n_o(busy_n),
    .op_done_o(op_done), .op_err_o(op_err)
  );

  // Reference: page contents as plain words, erased state is all-ones
  logic [DW-1:0] model [NPAGES][PW];
  logic [DW-1:0] rd_q[$];
  int            evt_q[$];
  int            n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_busy_n"},    32'(busy_n), 1);
    chk({tag, "_rd_valid"},  32'(rd_valid), 0);
    chk({tag, "_rd_data"},   32'(rd_data), 0);
    chk({tag, "_op_done"},   32'(op_done), 0);
    chk({tag, "_op_err"},    32'(op_err), 0);
  endtask

  // Monitor: compares every emitted read word and completion event
  initial begin : monitor
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else begin
        if (rd_valid) begin
          chk("rd_busy_n", 32'(busy_n), 1);
          if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 0);
          else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
          run++;
        end else if (run > 0) begin
          chk("rd_burst_len", run, PW);
          run = 0;
        end
        if (op_done || op_err) begin
          if (evt_q.size() == 0) chk("evt_unexpected", 32'({op_err, op_done}), 0);
          else chk("evt_kind", 32'({op_err, op_done}), evt_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [AW-1:0] a);
    int t;
    t = 0;
    while (!cmd_ready && t < 200) begin @(posedge clk); #1; t++; end
    chk("issue_ready", 32'(cmd_ready), 1);
    cmd = c; addr = a; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Follows an operation back to IDLE, counting busy cycles; optionally
  // hammers cmd_valid/wr_valid the whole time to show they are ignored.
  task automatic wait_op(input string name, input int exp_busy, input bit poke);
    int cnt;
    bit done;
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy_n) begin
        cnt++;
        if (poke) chk("ready_low_in_busy", 32'(cmd_ready), 0);
      end
      if (cmd_ready) begin
        done = 1'b1;
        cmd_valid = 1'b0; wr_valid = 1'b0;
        chk({name, "_done_pulse"}, 32'(op_done), 1);
      end else if (poke) begin
        cmd_valid = 1'b1; cmd = MEM_PAGE_READ; addr = AW'($urandom);
        wr_valid = 1'b1; wr_data = DW'($urandom);
      end
    end
    chk({name, "_finished"}, 32'(done), 1);
    chk({name, "_busy_cycles"}, cnt, exp_busy);
    @(posedge clk); #1;
  endtask

  task automatic do_erase(input int blk, input bit poke);
    evt_q.push_back(EV_DONE);
    issue(MEM_ERASE, AW'(blk * PPB));
    wait_op("erase", EC, poke);
    for (int p = blk * PPB; p < (blk + 1) * PPB; p++)
      for (int k = 0; k < PW; k++) model[p][k] = '1;
  endtask

  task automatic do_read(input int pg);
    for (int k = 0; k < PW; k++) rd_q.push_back(model[pg][k]);
    evt_q.push_back(EV_DONE);
    issue(MEM_PAGE_READ, AW'(pg));
    wait_op("read", RC, 1'b0);
  endtask

  // gap_after: word index followed by a 2-cycle wr_valid gap (-1 for none)
  // abort_at: busy cycle on which reset is pulled (0 for a normal program)
  task automatic do_program(input int pg, input logic [PW-1:0][DW-1:0] d,
                            input int gap_after, input bit rnd_gap, input int abort_at);
    int gaps, cnt;
    if (abort_at == 0) evt_q.push_back(EV_DONE);
    issue(MEM_PROGRAM_PAGE, AW'(pg));
    for (int w = 0; w < PW; w++) begin
      gaps = (w == gap_after + 1) ? 2 : (rnd_gap ? int'($urandom_range(0, 2)) : 0);
      wr_valid = 1'b0;
      repeat (gaps) begin @(posedge clk); #1; chk("load_busy_n", 32'(busy_n), 1); end
      wr_valid = 1'b1; wr_data = d[w];
      @(posedge clk); #1;
      if (w < PW - 1) chk("load_busy_n", 32'(busy_n), 1);
    end
    wr_valid = 1'b0;
    if (abort_at == 0) begin
      wait_op("program", PC, 1'b0);
      for (int k = 0; k < PW; k++) model[pg][k] = model[pg][k] & d[k];
    end else begin
      cnt = 0;
      for (int i = 0; i < 100 && cnt < abort_at; i++) begin
        @(negedge clk);
        if (!busy_n) cnt++;
      end
      chk("abort_reached", cnt, abort_at);
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("abort");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_bad(input logic [2:0] c, input logic [AW-1:0] a);
    evt_q.push_back(EV_ERR);
    issue(c, a);
    chk("err_pulse", 32'(op_err), 1);
    repeat (3) begin
      @(negedge clk);
      chk("err_cmd_ready", 32'(cmd_ready), 1);
      chk("err_busy_n", 32'(busy_n), 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [PW-1:0][DW-1:0] d;
    int op, pg;
    for (int p = 0; p < NPAGES; p++)
      for (int k = 0; k < PW; k++) model[p][k] = '1;

    #12 chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Erase everything so array contents are known; block 2 with cmd/wr noise
    do_erase(1, 1'b0);
    do_erase(0, 1'b0);
    do_erase(2, 1'b1);
    do_erase(3, 1'b0);
    do_read(4);

    for (int w = 0; w < PW; w++) d[w] = DW'(16'h1000 + w);
    do_program(5, d, 3, 1'b0, 0);
    do_read(5);
    for (int w = 0; w < PW; w++) d[w] = 16'h0F0F;
    do_program(5, d, -1, 1'b0, 0);
    do_read(5);

    do_bad(3'd5, 16'h0001);
    do_bad(MEM_ERASE, 16'h0010);
    do_bad(3'd7, 16'h0003);
    do_bad(MEM_PAGE_READ, 16'hFFF2);

    for (int it = 0; it < 16; it++) begin
      op = int'($urandom_range(0, 2));
      pg = int'($urandom_range(0, NPAGES - 1));
      case (op)
        0: do_erase(pg / PPB, 1'($urandom_range(0, 1)));
        1: begin
          for (int w = 0; w < PW; w++) d[w] = DW'($urandom);
          do_program(pg, d, -1, 1'b1, 0);
        end
        default: do_read(pg);
      endcase
    end

    // Reset during program busy: page must keep its erased contents
    do_erase(2, 1'b0);
    for (int w = 0; w < PW; w++) d[w] = '0;
    do_program(9, d, -1, 1'b0, 5);
    do_read(9);
    do_read(8);

    repeat (5) @(posedge clk);
    #1;
    chk("rd_q_drained", rd_q.size(), 0);
    chk("evt_q_drained", evt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
